// File: rtl/rv_mem_queue_pkg.sv
`default_nettype none
// ============================================================================
// Package  : rv_mem_queue_pkg
// Brief    : Size codes, issue-FSM states and alignment helper for rv_mem_queue.
// Revision : 1.0 - initial release
// ============================================================================
package rv_mem_queue_pkg;

  localparam logic [1:0] c_MEM_B = 2'd0;
  localparam logic [1:0] c_MEM_H = 2'd1;
  localparam logic [1:0] c_MEM_W = 2'd2;
  localparam logic [1:0] c_MEM_D = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } mq_state_e;

  // A doubleword access is illegal outright when the datapath has no 64-bit lanes.
  function automatic logic mem_misaligned(input logic [1:0] size,
                                          input logic [2:0] addr_lo,
                                          input logic       has_dword);
    logic r;
    case (size)
      c_MEM_B: r = 1'b0;
      c_MEM_H: r = addr_lo[0];
      c_MEM_W: r = |addr_lo[1:0];
      default: r = ~has_dword | (|addr_lo);
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rv_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rv_sync_fifo
// Brief    : Single-clock FIFO with registered occupancy count and full/empty.
// Revision : 1.0 - initial release
// ============================================================================
module rv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_wdata,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_rdata,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int c_PW = $clog2(DEPTH);
  localparam int c_CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_PW-1:0]  r_wr_ptr;
  logic [c_PW-1:0]  r_rd_ptr;
  logic [c_CW-1:0]  r_count;

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + c_PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + c_PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + c_CW'(1);
        2'b01:   r_count <= r_count - c_CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == c_CW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/rv_mem_queue.sv
`default_nettype none
// ============================================================================
// Module   : rv_mem_queue
// Brief    : Load/store issue queue: aligns store lanes, drains in order over a
//            req/ack bus and returns extracted, extended load data.
// Revision : 1.0 - initial release
// ============================================================================
module rv_mem_queue
  import rv_mem_queue_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ALEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_store,
  input  logic [2:0]        i_funct3,
  input  logic [ALEN-1:0]   i_addr,
  input  logic [XLEN-1:0]   i_wdata,
  output logic              o_misalign,
  output logic              o_empty,
  output logic              o_bus_req,
  input  logic              i_bus_ack,
  output logic [ALEN-1:0]   o_bus_addr,
  output logic              o_bus_we,
  output logic [XLEN-1:0]   o_bus_wdata,
  output logic [XLEN/8-1:0] o_bus_wsel,
  input  logic [XLEN-1:0]   i_bus_rdata,
  output logic              o_ld_valid,
  output logic [XLEN-1:0]   o_ld_data
);

  localparam int c_NB = XLEN / 8;
  localparam int c_OB = $clog2(c_NB);
  localparam int c_CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ALEN-1:0] addr;
    logic            we;
    logic [XLEN-1:0] wdata;
    logic [c_NB-1:0] wsel;
    logic [2:0]      funct3;
    logic [c_OB-1:0] offset;
  } mem_entry_t;

  localparam int c_EW = $bits(mem_entry_t);

  mq_state_e         r_state;
  mq_state_e         w_state_nxt;
  mem_entry_t        w_new;
  mem_entry_t        w_head;
  logic [c_CW-1:0]   w_count;
  logic              w_full;
  logic              w_fifo_empty;
  logic              w_illegal;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_req;
  logic [XLEN-1:0]   w_repl;
  logic [c_NB-1:0]   w_mask;
  logic [XLEN-1:0]   w_shifted;
  logic [XLEN-1:0]   w_left;
  logic signed [XLEN-1:0] w_sext;
  logic [XLEN-1:0]   w_ld_ext;
  logic [7:0]        w_ext_sh;
  logic              r_misalign;
  logic              r_ld_valid;
  logic [XLEN-1:0]   r_ld_data;

  assign w_illegal = mem_misaligned(i_funct3[1:0], i_addr[2:0], XLEN == 64);
  assign w_accept  = i_valid & o_ready;
  assign w_push    = w_accept & ~w_illegal;
  assign w_req     = (r_state == ST_REQ);
  assign w_pop     = w_req & i_bus_ack;

  always_comb begin
    w_repl = i_wdata;
    w_mask = '1;
    case (i_funct3[1:0])
      c_MEM_B: begin w_repl = {c_NB{i_wdata[7:0]}};        w_mask = c_NB'(1);  end
      c_MEM_H: begin w_repl = {(c_NB/2){i_wdata[15:0]}};   w_mask = c_NB'(3);  end
      c_MEM_W: begin w_repl = {(c_NB/4){i_wdata[31:0]}};   w_mask = c_NB'(15); end
      default: begin w_repl = i_wdata;                     w_mask = '1;        end
    endcase
  end

  always_comb begin
    w_new.addr   = i_addr;
    w_new.we     = i_store;
    w_new.wdata  = w_repl;
    w_new.wsel   = w_mask << i_addr[c_OB-1:0];
    w_new.funct3 = i_funct3;
    w_new.offset = i_addr[c_OB-1:0];
  end

  rv_sync_fifo #(
    .WIDTH (c_EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (w_push),
    .i_wdata   (w_new),
    .i_pop     (w_pop),
    .o_rdata   (w_head),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_fifo_empty)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  // A push landing with the final ack keeps REQ asserted so there is no idle gap.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (!w_fifo_empty || w_push) w_state_nxt = ST_REQ;
      ST_REQ:  if (i_bus_ack && (w_count <= c_CW'(1)) && !w_push) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend by a shift pair.
  always_comb begin
    w_shifted = i_bus_rdata >> {w_head.offset, 3'b000};
    w_ext_sh  = 8'(XLEN) - (8'd8 << w_head.funct3[1:0]);
    w_left    = w_shifted << w_ext_sh;
  end
  assign w_sext   = $signed(w_left) >>> w_ext_sh;
  assign w_ld_ext = w_head.funct3[2] ? (w_left >> w_ext_sh) : w_sext;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_misalign <= 1'b0;
      r_ld_valid <= 1'b0;
      r_ld_data  <= '0;
    end else begin
      r_misalign <= w_accept & w_illegal;
      r_ld_valid <= w_pop & ~w_head.we;
      if (w_pop && !w_head.we) r_ld_data <= w_ld_ext;
    end
  end

  assign o_ready     = ~w_full;
  assign o_empty     = w_fifo_empty & (r_state == ST_IDLE);
  assign o_misalign  = r_misalign;
  assign o_bus_req   = w_req;
  assign o_bus_addr  = w_req ? (w_head.addr & ~ALEN'(c_NB - 1)) : '0;
  assign o_bus_we    = w_req & w_head.we;
  assign o_bus_wdata = w_req ? w_head.wdata : '0;
  assign o_bus_wsel  = w_req ? w_head.wsel : '0;
  assign o_ld_valid  = r_ld_valid;
  assign o_ld_data   = r_ld_data;

endmodule
`default_nettype wire

// File: tb/tb_rv_mem_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv_mem_queue
// Brief    : Directed bench for rv_mem_queue (XLEN=32 with queue model, XLEN=64 directed).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv_mem_queue;

  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // XLEN=32 instance
  logic        valid = 0, store = 0, ack = 0;
  logic [2:0]  f3 = 0;
  logic [31:0] addr = 0, wdata = 0, rdata = 0;
  logic        ready, misalign, empty, req, we, ld_valid;
  logic [31:0] baddr, bwdata, ld_data;
  logic [3:0]  wsel;

  // XLEN=64 instance
  logic        v64 = 0, st64 = 0, ack64 = 0;
  logic [2:0]  f3_64 = 0;
  logic [31:0] a64 = 0;
  logic [63:0] wd64 = 0, rd64 = 0;
  logic        rdy64, mis64, emp64, req64, we64, ldv64;
  logic [31:0] ba64;
  logic [63:0] bwd64, ldd64;
  logic [7:0]  ws64;

  rv_mem_queue #(.XLEN(32), .ALEN(32), .DEPTH(DEPTH)) u_dut32 (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid), .o_ready(ready),
    .i_store(store), .i_funct3(f3), .i_addr(addr), .i_wdata(wdata),
    .o_misalign(misalign), .o_empty(empty), .o_bus_req(req), .i_bus_ack(ack),
    .o_bus_addr(baddr), .o_bus_we(we), .o_bus_wdata(bwdata), .o_bus_wsel(wsel),
    .i_bus_rdata(rdata), .o_ld_valid(ld_valid), .o_ld_data(ld_data)
  );

  rv_mem_queue #(.XLEN(64), .ALEN(32), .DEPTH(DEPTH)) u_dut64 (
    .i_clk(clk), .i_reset_n(rst_n), .i_valid(v64), .o_ready(rdy64),
    .i_store(st64), .i_funct3(f3_64), .i_addr(a64), .i_wdata(wd64),
    .o_misalign(mis64), .o_empty(emp64), .o_bus_req(req64), .i_bus_ack(ack64),
    .o_bus_addr(ba64), .o_bus_we(we64), .o_bus_wdata(bwd64), .o_bus_wsel(ws64),
    .i_bus_rdata(rd64), .o_ld_valid(ldv64), .o_ld_data(ldd64)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model of the XLEN=32 instance ----------------
  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wsel;
    logic [2:0]  f3;
  } req_t;

  req_t        mq[$];
  req_t        m_e;
  logic        m_take = 1'b0;
  logic        m_mis  = 1'b0;
  logic        m_ldv  = 1'b0;
  logic [31:0] m_ldd  = '0;

  function automatic logic spec_misaligned(input logic [2:0] fn, input logic [31:0] a);
    case (fn[1:0])
      2'd0:    return 1'b0;
      2'd1:    return a[0];
      2'd2:    return a[1:0] != 2'd0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] spec_wdata(input logic [2:0] fn, input logic [31:0] d);
    case (fn[1:0])
      2'd0:    return {4{d[7:0]}};
      2'd1:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] spec_wsel(input logic [2:0] fn, input logic [31:0] a);
    int m;
    m = (1 << (1 << fn[1:0])) - 1;
    return 4'(m << a[1:0]);
  endfunction

  function automatic logic [31:0] spec_load(input logic [2:0] fn, input logic [31:0] a,
                                            input logic [31:0] rd);
    int          bits;
    logic [31:0] v, mask;
    bits = 8 << fn[1:0];
    v    = rd >> (8 * a[1:0]);
    mask = (bits == 32) ? 32'hFFFF_FFFF : ((32'd1 << bits) - 32'd1);
    v    = v & mask;
    if (!fn[2] && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_mis = 1'b0;
      m_ldv = 1'b0;
      m_ldd = '0;
    end else begin
      m_take = (mq.size() < DEPTH);
      m_mis  = 1'b0;
      m_ldv  = 1'b0;
      if (mq.size() > 0 && ack) begin
        m_e = mq.pop_front();
        if (!m_e.we) begin
          m_ldv = 1'b1;
          m_ldd = spec_load(m_e.f3, m_e.addr, rdata);
        end
      end
      if (valid && m_take) begin
        if (spec_misaligned(f3, addr)) m_mis = 1'b1;
        else begin
          m_e.addr  = addr;
          m_e.we    = store;
          m_e.wdata = spec_wdata(f3, wdata);
          m_e.wsel  = spec_wsel(f3, addr);
          m_e.f3    = f3;
          mq.push_back(m_e);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("ready", ready, mq.size() < DEPTH);
    chk("bus_req", req, mq.size() > 0);
    chk("empty", empty, mq.size() == 0);
    chk("misalign", misalign, m_mis);
    chk("ld_valid", ld_valid, m_ldv);
    chk("ld_data", ld_data, m_ldd);
    if (mq.size() > 0) begin
      chk("bus_addr", baddr, mq[0].addr & 32'hFFFF_FFFC);
      chk("bus_we", we, mq[0].we);
      chk("bus_wdata", bwdata, mq[0].wdata);
      chk("bus_wsel", wsel, mq[0].wsel);
    end else begin
      chk("bus_idle_fields", {baddr, we, bwdata, wsel}, '0);
    end
  end

  // ---------------- stimulus helpers (start and end at posedge+1) ----------------
  task automatic issue(input logic st, input logic [2:0] fn, input logic [31:0] a,
                       input logic [31:0] d);
    logic took;
    took  = 1'b0;
    valid = 1'b1; store = st; f3 = fn; addr = a; wdata = d;
    for (int i = 0; i < 20 && !took; i++) begin
      took = ready;
      @(posedge clk); #1;
    end
    valid = 1'b0;
    if (!took) begin
      checks++; errors++;
      $display("FAIL issue_timeout: got ready=0 expected accept of addr %h", a);
    end
  endtask

  task automatic respond(input logic [31:0] rd);
    int n;
    n = 0;
    while (!req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req) begin
      checks++; errors++;
      $display("FAIL respond_timeout: got bus_req=0 expected 1");
    end else begin
      ack = 1'b1; rdata = rd;
      @(posedge clk); #1;
      ack = 1'b0; rdata = '0;
    end
  endtask

  initial begin
    @(posedge clk); #1;
    chk("rst_ready", ready, 1);
    chk("rst_empty", empty, 1);
    chk("rst_req", req, 0);
    chk("rst_ld_valid", ld_valid, 0);
    chk("rst_ld_data", ld_data, 0);
    chk("rst_misalign", misalign, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // SB lane replication and byte select
    issue(1, 3'b000, 32'h1003, 32'h0000_00A5);
    chk("t1_req", req, 1);
    chk("t1_addr", baddr, 32'h1000);
    chk("t1_wdata", bwdata, 32'hA5A5_A5A5);
    chk("t1_wsel", wsel, 4'b1000);
    chk("t1_we", we, 1);
    respond(32'h0);

    issue(1, 3'b001, 32'h1002, 32'h1234_BEEF);
    chk("sh_wdata", bwdata, 32'hBEEF_BEEF);
    chk("sh_wsel", wsel, 4'b1100);
    respond(32'h0);

    // loads: signed/unsigned half, byte lanes, word
    issue(0, 3'b001, 32'h2002, 32'h0);
    respond(32'h8001_1234);
    chk("lh_valid", ld_valid, 1);
    chk("lh_data", ld_data, 32'hFFFF_8001);
    issue(0, 3'b101, 32'h2002, 32'h0);
    respond(32'h8001_1234);
    chk("lhu_data", ld_data, 32'h0000_8001);
    issue(0, 3'b100, 32'h2001, 32'h0);
    respond(32'h0000_F700);
    chk("lbu_data", ld_data, 32'h0000_00F7);
    issue(0, 3'b000, 32'h2003, 32'h0);
    respond(32'h8500_0000);
    chk("lb_data", ld_data, 32'hFFFF_FF85);
    issue(0, 3'b010, 32'h2004, 32'h0);
    respond(32'h1234_5678);
    chk("lw_data", ld_data, 32'h1234_5678);

    // misaligned / illegal
    issue(1, 3'b010, 32'h3002, 32'h11);
    chk("t3_misalign", misalign, 1);
    chk("t3_req", req, 0);
    chk("t3_empty", empty, 1);
    issue(0, 3'b001, 32'h2001, 32'h0);
    chk("mis_lh", misalign, 1);
    issue(0, 3'b011, 32'h2000, 32'h0);
    chk("mis_ld32", misalign, 1);

    // fill to DEPTH, fifth waits, then drain in order
    for (int i = 0; i < 4; i++) issue(1, 3'b010, 32'h100 + 32'(4 * i), 32'h1111_0000 + 32'(i));
    chk("t4_full", ready, 0);
    fork
      issue(1, 3'b010, 32'h110, 32'h1111_0004);
      begin
        repeat (2) begin @(posedge clk); #1; end
        respond(32'h0);
      end
    join
    chk("t4_head", baddr, 32'h104);
    for (int i = 0; i < 4; i++) respond(32'h0);

    // push coincides with final ack
    issue(1, 3'b010, 32'h500, 32'hAAAA_0000);
    fork
      issue(1, 3'b010, 32'h504, 32'hBBBB_0001);
      respond(32'h0);
    join
    chk("t5_req", req, 1);
    chk("t5_addr", baddr, 32'h504);
    respond(32'h0);

    // XLEN=64: doubleword and word-in-upper-half loads
    v64 = 1; st64 = 0; f3_64 = 3'b011; a64 = 32'h4008;
    @(posedge clk); #1; v64 = 0;
    chk("t6_req", req64, 1);
    chk("t6_addr", ba64, 32'h4008);
    ack64 = 1; rd64 = 64'h8000_0000_0000_0001;
    @(posedge clk); #1; ack64 = 0;
    chk("t6_ldv", ldv64, 1);
    chk("t6_ldd", ldd64, 64'h8000_0000_0000_0001);
    v64 = 1; st64 = 0; f3_64 = 3'b010; a64 = 32'h4004;
    @(posedge clk); #1; v64 = 0;
    ack64 = 1; rd64 = 64'h8000_0001_0000_0000;
    @(posedge clk); #1; ack64 = 0;
    chk("t6_lw64", ldd64, 64'hFFFF_FFFF_8000_0001);

    v64 = 1; st64 = 1; f3_64 = 3'b011; a64 = 32'h4010; wd64 = 64'h0123_4567_89AB_CDEF;
    @(posedge clk); #1; v64 = 0;
    chk("t6_sd_req", req64, 1);
    chk("t6_sd_wsel", ws64, 8'hFF);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req", req64, 0);
    chk("t6_rst_empty", emp64, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
